// File: rtl/cpu_pkg.sv
// Shared constants, status bit map, write-back state encoding and held-op record
// for the ALU write-back stage.
package cpu_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 4;
  localparam int STAT_W = 13;
  localparam int HALF_W = 10;

  localparam int ST_Z    = 0;
  localparam int ST_S    = 1;
  localparam int ST_C    = 2;
  localparam int ST_MODE = 3;
  localparam int ST_TRAP = 4;

  localparam int FE_Z = 0;
  localparam int FE_S = 1;
  localparam int FE_C = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic              mode;
    logic              dual;
    logic [ADDR_W-1:0] dest_a;
    logic [DATA_W-1:0] data_a;
    logic [ADDR_W-1:0] dest_b;
    logic [DATA_W-1:0] data_b;
    logic [2:0]        flag_we;
    logic              zero;
    logic              sign;
    logic              carry;
  } wb_op_t;

  // Half-word results only carry their low HALF_W bits to the register file.
  function automatic logic [DATA_W-1:0] size_data(input logic [DATA_W-1:0] d,
                                                  input logic full);
    logic [DATA_W-1:0] r;
    if (full) begin
      r = d;
    end else begin
      r = {{(DATA_W-HALF_W){1'b0}}, d[HALF_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_status_reg.sv
// 13-bit status register: flag commit, trap set/clear and the trap-gated
// software write, merged with trap > software write > flag commit.
module alu_status_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic              commit_mode,
  input  logic [2:0]        flag_we,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              trap_set,
  input  logic              trap_clr,
  input  logic              stat_we,
  input  logic [STAT_W-1:0] stat_wdata,
  output logic [STAT_W-1:0] status_reg,
  output logic              trap_flag
);

  logic [STAT_W-1:0] stat_q;
  logic [STAT_W-1:0] merge_s;
  logic [STAT_W-1:0] stat_d;

  // Next status value; software write replaces a same-edge flag commit entirely.
  always_comb begin
    merge_s = stat_q;
    if (stat_we && stat_q[ST_TRAP]) begin
      merge_s = stat_wdata;
    end else if (commit) begin
      merge_s[ST_Z]    = flag_we[FE_Z] ? flag_zero  : stat_q[ST_Z];
      merge_s[ST_S]    = flag_we[FE_S] ? flag_sign  : stat_q[ST_S];
      merge_s[ST_C]    = flag_we[FE_C] ? flag_carry : stat_q[ST_C];
      merge_s[ST_MODE] = commit_mode;
    end else begin
      merge_s = stat_q;
    end
    stat_d          = merge_s;
    stat_d[ST_TRAP] = trap_set ? 1'b1 : (trap_clr ? 1'b0 : merge_s[ST_TRAP]);
  end

  // Status register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= {STAT_W{1'b0}};
    end else begin
      stat_q <= stat_d;
    end
  end

  assign status_reg = stat_q;
  assign trap_flag  = stat_q[ST_TRAP];

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: one-entry holding register, write-port sequencer
// (one cycle for single ops, two for swap) and the status register.
module alu_writeback
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic              res_mode,
  input  logic              res_dual,
  input  logic [ADDR_W-1:0] res_dest_a,
  input  logic [DATA_W-1:0] res_data_a,
  input  logic [ADDR_W-1:0] res_dest_b,
  input  logic [DATA_W-1:0] res_data_b,
  input  logic [2:0]        res_flag_we,
  input  logic              res_zero,
  input  logic              res_sign,
  input  logic              res_carry,
  input  logic              trap_set,
  input  logic              trap_clr,
  input  logic              stat_we,
  input  logic [STAT_W-1:0] stat_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [STAT_W-1:0] status_reg,
  output logic              trap_flag
);

  wb_state_e         state_q, state_d;
  wb_op_t            hold_q, hold_d;
  logic              ready_q, ready_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              transfer_s;
  logic              commit_s;

  // Sequencer next state; ready and rf_* are precomputed from the next state so they register cleanly.
  always_comb begin
    transfer_s = res_valid && ready_q;
    hold_d     = hold_q;
    if (transfer_s) begin
      hold_d = '{mode: res_mode, dual: res_dual, dest_a: res_dest_a, data_a: res_data_a,
                 dest_b: res_dest_b, data_b: res_data_b, flag_we: res_flag_we,
                 zero: res_zero, sign: res_sign, carry: res_carry};
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      IDLE:    state_d = transfer_s ? WR_A : IDLE;
      WR_A: begin
        if (hold_q.dual) begin
          state_d = WR_B;
        end else begin
          state_d = transfer_s ? WR_A : IDLE;
        end
      end
      WR_B:    state_d = transfer_s ? WR_A : IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != WR_A) || !hold_d.dual;
    rf_we_d = (state_d != IDLE);
    case (state_d)
      WR_A: begin
        rf_waddr_d = hold_d.dest_a;
        rf_wdata_d = size_data(hold_d.data_a, hold_d.mode);
      end
      WR_B: begin
        rf_waddr_d = hold_d.dest_b;
        rf_wdata_d = size_data(hold_d.data_b, hold_d.mode);
      end
      default: begin
        rf_waddr_d = {ADDR_W{1'b0}};
        rf_wdata_d = {DATA_W{1'b0}};
      end
    endcase
  end

  // Sequencer, holding register and write-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      ready_q    <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {ADDR_W{1'b0}};
      rf_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign commit_s  = (state_q == WR_A);
  assign res_ready = ready_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

  alu_status_reg u_status (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit_s),
    .commit_mode (hold_q.mode),
    .flag_we     (hold_q.flag_we),
    .flag_zero   (hold_q.zero),
    .flag_sign   (hold_q.sign),
    .flag_carry  (hold_q.carry),
    .trap_set    (trap_set),
    .trap_clr    (trap_clr),
    .stat_we     (stat_we),
    .stat_wdata  (stat_wdata),
    .status_reg  (status_reg),
    .trap_flag   (trap_flag)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: vector table for single/dual ops and
// flag commits, write scoreboard, hand sequences for stall, trap and reset.
module tb_alu_writeback;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              res_valid = 1'b0;
  logic              res_ready;
  logic              res_mode = 1'b0;
  logic              res_dual = 1'b0;
  logic [ADDR_W-1:0] res_dest_a = '0;
  logic [DATA_W-1:0] res_data_a = '0;
  logic [ADDR_W-1:0] res_dest_b = '0;
  logic [DATA_W-1:0] res_data_b = '0;
  logic [2:0]        res_flag_we = 3'b000;
  logic              res_zero = 1'b0;
  logic              res_sign = 1'b0;
  logic              res_carry = 1'b0;
  logic              trap_set = 1'b0;
  logic              trap_clr = 1'b0;
  logic              stat_we = 1'b0;
  logic [STAT_W-1:0] stat_wdata = '0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [STAT_W-1:0] status_reg;
  logic              trap_flag;

  alu_writeback dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_mode(res_mode), .res_dual(res_dual), .res_dest_a(res_dest_a),
    .res_data_a(res_data_a), .res_dest_b(res_dest_b), .res_data_b(res_data_b),
    .res_flag_we(res_flag_we), .res_zero(res_zero), .res_sign(res_sign),
    .res_carry(res_carry), .trap_set(trap_set), .trap_clr(trap_clr),
    .stat_we(stat_we), .stat_wdata(stat_wdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .status_reg(status_reg),
    .trap_flag(trap_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        dual;
    logic [3:0]  dest_a;
    logic [19:0] data_a;
    logic [3:0]  dest_b;
    logic [19:0] data_b;
    logic [2:0]  fwe;
    logic        z;
    logic        s;
    logic        c;
    logic [12:0] exp_stat;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [19:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  sb_q[$];
  vec_t vecs[7];

  function automatic logic [19:0] exp_data(input logic [19:0] d, input logic mode);
    return mode ? d : (d & 20'h003FF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send(input vec_t v, output int waits);
    wr_t e;
    res_mode = v.mode;     res_dual = v.dual;
    res_dest_a = v.dest_a; res_data_a = v.data_a;
    res_dest_b = v.dest_b; res_data_b = v.data_b;
    res_flag_we = v.fwe;   res_zero = v.z; res_sign = v.s; res_carry = v.c;
    res_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!res_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!res_ready) begin
      check("ready_timeout", {31'd0, res_ready}, 32'd1);
      res_valid = 1'b0;
    end else begin
      e.addr = v.dest_a; e.data = exp_data(v.data_a, v.mode);
      sb_q.push_back(e);
      if (v.dual) begin
        e.addr = v.dest_b; e.data = exp_data(v.data_b, v.mode);
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      res_valid = 1'b0;
    end
  endtask

  // Called at a negedge; the pulse covers the next rising edge and is checked at the following negedge.
  task automatic pulse(input logic ts, input logic tc, input logic we, input logic [12:0] wd);
    trap_set = ts; trap_clr = tc; stat_we = we; stat_wdata = wd;
    @(posedge clk);
    #1;
    trap_set = 1'b0; trap_clr = 1'b0; stat_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_stat(input string name, input logic [12:0] exp);
    check(name, {19'd0, status_reg}, {19'd0, exp});
    check({name, "_trap"}, {31'd0, trap_flag}, {31'd0, exp[4]});
  endtask

  // Write scoreboard: every rf write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && rf_we) begin
      if (sb_q.size() == 0) begin
        check("rf_spurious", {28'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("rf_waddr", {28'd0, rf_waddr}, {28'd0, e.addr});
        check("rf_wdata", {12'd0, rf_wdata}, {12'd0, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    vec_t d;
    vec_t q;

    vecs[0] = '{1'b1, 1'b0, 4'd3,  20'hABCDE, 4'd0,  20'h00000, 3'b001, 1'b0, 1'b0, 1'b0, 13'h008};
    vecs[1] = '{1'b0, 1'b0, 4'd5,  20'hFFFFF, 4'd0,  20'h00000, 3'b111, 1'b0, 1'b1, 1'b1, 13'h006};
    vecs[2] = '{1'b1, 1'b0, 4'd7,  20'h00000, 4'd0,  20'h00000, 3'b001, 1'b1, 1'b0, 1'b0, 13'h00F};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 20'h80000, 4'd0,  20'h00000, 3'b010, 1'b0, 1'b0, 1'b0, 13'h00D};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  20'h7FFFF, 4'd0,  20'h00000, 3'b000, 1'b1, 1'b1, 1'b1, 13'h005};
    vecs[5] = '{1'b1, 1'b1, 4'd6,  20'h13579, 4'd8,  20'hFFFFF, 3'b100, 1'b0, 1'b0, 1'b0, 13'h009};
    vecs[6] = '{1'b0, 1'b1, 4'd12, 20'hFFC00, 4'd13, 20'h12345, 3'b000, 1'b0, 1'b0, 1'b0, 13'h001};

    #12;
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {28'd0, rf_waddr}, 32'd0);
    check("rst_wdata", {12'd0, rf_wdata}, 32'd0);
    check_stat("rst_status", 13'h000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      sync();
      send(vecs[i], w);
      @(negedge clk);
      check("rf_we_latency", {31'd0, rf_we}, 32'd1);
      repeat (2) @(negedge clk);
      check("rf_we_idle", {31'd0, rf_we}, 32'd0);
      check_stat("vec_status", vecs[i].exp_stat);
    end

    // Swap with a second op queued behind it.
    d = '{1'b1, 1'b1, 4'd1, 20'h12345, 4'd2, 20'h54321, 3'b000, 1'b0, 1'b0, 1'b0, 13'h009};
    q = '{1'b1, 1'b0, 4'd9, 20'h0F0F0, 4'd0, 20'h00000, 3'b000, 1'b0, 1'b0, 1'b0, 13'h009};
    sync();
    send(d, w);
    send(q, w);
    check("dual_stall_cycles", w, 32'd1);
    @(negedge clk);
    check("queued_we", {31'd0, rf_we}, 32'd1);
    check("queued_addr", {28'd0, rf_waddr}, 32'd9);
    repeat (2) @(negedge clk);
    check_stat("dual_status", 13'h009);

    // Trap gating, software write and same-edge priorities.
    pulse(1'b0, 1'b0, 1'b1, 13'h1FE0);
    check_stat("swr_no_trap", 13'h009);
    pulse(1'b1, 1'b0, 1'b0, 13'h0000);
    check_stat("trap_set", 13'h019);
    pulse(1'b0, 1'b0, 1'b1, 13'h1FF0);
    check_stat("swr_in_trap", 13'h1FF0);
    pulse(1'b0, 1'b1, 1'b0, 13'h0000);
    check_stat("trap_clr", 13'h1FE0);
    pulse(1'b1, 1'b1, 1'b0, 13'h0000);
    check_stat("trap_set_wins", 13'h1FF0);

    d = '{1'b1, 1'b0, 4'd4, 20'h00001, 4'd0, 20'h00000, 3'b100, 1'b0, 1'b0, 1'b1, 13'h000};
    sync();
    send(d, w);
    stat_we = 1'b1;
    stat_wdata = 13'h0010;
    @(posedge clk);
    #1;
    stat_we = 1'b0;
    @(negedge clk);
    check_stat("swr_over_commit", 13'h0010);
    pulse(1'b0, 1'b1, 1'b1, 13'h1FFF);
    check_stat("clr_over_swr", 13'h1FEF);

    // Asynchronous reset while the second half of a swap is on the write port.
    d = '{1'b1, 1'b1, 4'd10, 20'h11111, 4'd11, 20'h22222, 3'b111, 1'b1, 1'b1, 1'b1, 13'h000};
    sync();
    send(d, w);
    @(posedge clk);
    #2;
    check("pre_rst_addr", {28'd0, rf_waddr}, 32'd11);
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("mid_rst_waddr", {28'd0, rf_waddr}, 32'd0);
    check("mid_rst_wdata", {12'd0, rf_wdata}, 32'd0);
    check_stat("mid_rst_status", 13'h000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, res_ready}, 32'd1);

    d = '{1'b1, 1'b0, 4'd14, 20'h0BEEF, 4'd0, 20'h00000, 3'b001, 1'b1, 1'b0, 1'b0, 13'h009};
    sync();
    send(d, w);
    repeat (3) @(negedge clk);
    check_stat("recover_status", 13'h009);
    check("sb_drain", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
